// File: rtl/enc_scan_n.sv
// Sequential N-input priority encoder: captures a request vector, then serialises set bits
// as indices, one per handshake. Define LSB_FIRST_EN to scan lowest index first (default MSB-first).
module enc_scan_n #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  d,
    input  logic          load,
    output logic [AW-1:0] a,
    output logic          a_valid,
    input  logic          a_ready,
    output logic          busy,
    output logic          none,
    output logic [AW:0]   pop
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q;
    logic [N-1:0]  pend_q;
    logic [AW-1:0] a_q;
    logic          a_valid_q;
    logic          busy_q;
    logic          none_q;
    logic [AW:0]   pop_q;

    logic [N-1:0]  served_oh;
    logic [N-1:0]  pend_d;

    // NOTE: functions use blocking '=' on locals; only the always_ff below uses '<='.
    function automatic logic [AW-1:0] prio(input logic [N-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
`ifdef LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = AW'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = AW'(i);
        end
`endif
        return idx;
    endfunction

    function automatic logic [AW:0] popcount(input logic [N-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) cnt = cnt + 1'b1;
        end
        return cnt;
    endfunction

    // Pending set with the currently presented index removed.
    always_comb begin
        served_oh       = '0;
        served_oh[a_q]  = 1'b1;
        pend_d          = pend_q & ~served_oh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            none_q    <= 1'b0;
            pop_q     <= '0;
        end else begin
            none_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        pop_q <= popcount(d);
                        if (d != '0) begin
                            pend_q    <= d;
                            a_q       <= prio(d);
                            a_valid_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= SCAN;
                        end else begin
                            none_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (a_valid_q && a_ready) begin
                        pend_q <= pend_d;
                        if (pend_d == '0) begin
                            a_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            a_q <= prio(pend_d);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign none    = none_q;
    assign pop     = pop_q;

endmodule

// File: tb/tb_enc_scan_n.sv
// Directed self-checking bench for enc_scan_n (N=8 and N=4 instances); follows LSB_FIRST_EN if defined.
module tb_enc_scan_n;

`ifdef LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] d = '0;
    logic       load = 1'b0;
    logic       a_ready = 1'b0;
    logic [2:0] a;
    logic       a_valid, busy, none;
    logic [3:0] pop;

    logic [3:0] d4 = '0;
    logic       load4 = 1'b0;
    logic       a_ready4 = 1'b0;
    logic [1:0] a4;
    logic       a_valid4, busy4, none4;
    logic [2:0] pop4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enc_scan_n #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .d(d), .load(load), .a(a), .a_valid(a_valid),
        .a_ready(a_ready), .busy(busy), .none(none), .pop(pop)
    );

    enc_scan_n #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .d(d4), .load(load4), .a(a4), .a_valid(a_valid4),
        .a_ready(a_ready4), .busy(busy4), .none(none4), .pop(pop4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input int ea, input bit ev, input bit eb, input int ep);
        check({tag, ".a"},       32'(a),       32'(ea));
        check({tag, ".a_valid"}, 32'(a_valid), 32'(ev));
        check({tag, ".busy"},    32'(busy),    32'(eb));
        check({tag, ".none"},    32'(none),    32'(0));
        check({tag, ".pop"},     32'(pop),     32'(ep));
    endtask

    initial begin
        // Reset state (asynchronous assertion)
        #2;
        check8("reset", 0, 1'b0, 1'b0, 0);
        check("reset.a4", 32'(a4), 32'(0));
        check("reset.pop4", 32'(pop4), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // N=4, single MSB request
        load4 = 1'b1; d4 = 4'b1000;
        tick();
        load4 = 1'b0; d4 = '0;
        check("t1.a4", 32'(a4), 32'(3));
        check("t1.a_valid4", 32'(a_valid4), 32'(1));
        check("t1.pop4", 32'(pop4), 32'(1));
        check("t1.busy4", 32'(busy4), 32'(1));
        a_ready4 = 1'b1;
        tick();
        a_ready4 = 1'b0;
        check("t1.done.a_valid4", 32'(a_valid4), 32'(0));
        check("t1.done.busy4", 32'(busy4), 32'(0));
        check("t1.done.a4", 32'(a4), 32'(3));

        // Three-bit scan with continuous accept
        load = 1'b1; d = 8'b0010_0110; a_ready = 1'b1;
        tick();
        load = 1'b0; d = '0;
        check8("t2.c0", LSB ? 1 : 5, 1'b1, 1'b1, 3);
        tick();
        check8("t2.c1", 2, 1'b1, 1'b1, 3);
        tick();
        check8("t2.c2", LSB ? 5 : 1, 1'b1, 1'b1, 3);
        tick();
        check8("t2.end", LSB ? 5 : 1, 1'b0, 1'b0, 3);

        // Zero load immediately after returning to IDLE
        load = 1'b1; d = 8'h00;
        tick();
        load = 1'b0;
        check("t3.none", 32'(none), 32'(1));
        check("t3.a_valid", 32'(a_valid), 32'(0));
        check("t3.busy", 32'(busy), 32'(0));
        check("t3.pop", 32'(pop), 32'(0));
        tick();
        check("t3.none_drop", 32'(none), 32'(0));

        // Stall holds the index; load during SCAN is ignored
        a_ready = 1'b0; load = 1'b1; d = 8'b0010_0110;
        tick();
        load = 1'b0; d = '0;
        check8("t4.load", LSB ? 1 : 5, 1'b1, 1'b1, 3);
        tick();
        check8("t4.stall1", LSB ? 1 : 5, 1'b1, 1'b1, 3);
        load = 1'b1; d = 8'hFF;
        tick();
        load = 1'b0; d = '0;
        check8("t4.stall2", LSB ? 1 : 5, 1'b1, 1'b1, 3);
        tick();
        check8("t4.stall3", LSB ? 1 : 5, 1'b1, 1'b1, 3);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check8("t4.accept", 2, 1'b1, 1'b1, 3);

        // Reset mid-scan takes effect without a clock edge
        rst_n = 1'b0;
        #1;
        check8("t5.rst", 0, 1'b0, 1'b0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        load = 1'b1; d = 8'h01;
        tick();
        load = 1'b0; d = '0;
        check8("t5.reload", 0, 1'b1, 1'b1, 1);
        a_ready = 1'b1;
        tick();
        check8("t5.end", 0, 1'b0, 1'b0, 1);

        // All bits set: full sweep and pop = N
        load = 1'b1; d = 8'hFF;
        tick();
        load = 1'b0; d = '0;
        for (int k = 0; k < 8; k++) begin
            check8($sformatf("t6.c%0d", k), LSB ? k : 7 - k, 1'b1, 1'b1, 8);
            tick();
        end
        check8("t6.end", LSB ? 7 : 0, 1'b0, 1'b0, 8);
        a_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
